// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module  : uc_multiciclo
// Brief   : Multicycle RV32I control unit with a shared req/ack memory port,
//           wait-state timeout and a sticky fault state.
// Rev     : 1.0
// ============================================================================
module uc_multiciclo #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk_UC,
  input  logic        rst_UC,
  input  logic [31:0] instr_UC,
  input  logic        zero_UC,
  input  logic        memAck_UC,
  output logic        memReq_UC,
  output logic        memWrite_UC,
  output logic        adrSrc_UC,
  output logic        irWrite_UC,
  output logic        pcWrite_UC,
  output logic        regWrite_UC,
  output logic        branch_UC,
  output logic [1:0]  aluSrcA_UC,
  output logic [1:0]  aluSrcB_UC,
  output logic [1:0]  resSrc_UC,
  output logic [1:0]  inmSrc_UC,
  output logic [2:0]  aluControl_UC,
  output logic [2:0]  type_UC,
  output logic [3:0]  state_UC,
  output logic        fault_UC
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_JAL    = 4'd9;
  localparam logic [3:0] S_BEQ    = 4'd10;
  localparam logic [3:0] S_FAULT  = 4'd11;

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_i     = 7'b0010011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_beq   = 7'b1100011;

  localparam logic [CNT_W-1:0] c_wait_max = CNT_W'(MEM_TIMEOUT - 1);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_wait;
  logic             w_mem_state;
  logic [6:0]       w_op;
  logic [2:0]       w_f3;
  logic             w_req, w_mwr, w_irw, w_pcw, w_rw;
  logic             w_unused;

  assign w_op     = instr_UC[6:0];
  assign w_f3     = instr_UC[14:12];
  assign w_unused = ^{instr_UC[31], instr_UC[29:15], instr_UC[11:7]};

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (memAck_UC) w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          c_op_load, c_op_store: w_next = S_MEMADR;
          c_op_r:                w_next = S_EXECR;
          c_op_i:                w_next = S_EXECI;
          c_op_jal:              w_next = S_JAL;
          c_op_beq:              w_next = S_BEQ;
          default:               w_next = S_FAULT;
        endcase
      end
      S_MEMADR: w_next = (w_op == c_op_load) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (memAck_UC) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (memAck_UC) w_next = S_FETCH;
      S_EXECR,
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_JAL:    w_next = S_ALUWB;
      S_BEQ:    w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;
    endcase
    // A late ack on the last allowed cycle still completes normally.
    if (w_mem_state && !memAck_UC && (r_wait == c_wait_max))
      w_next = S_FAULT;
  end

  always_ff @(posedge clk_UC) begin
    if (rst_UC) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || !w_mem_state)
        r_wait <= '0;
      else
        r_wait <= r_wait + 1'b1;
    end
  end

  always_comb begin
    w_req         = 1'b0;
    w_mwr         = 1'b0;
    w_irw         = 1'b0;
    w_pcw         = 1'b0;
    w_rw          = 1'b0;
    adrSrc_UC     = 1'b0;
    branch_UC     = 1'b0;
    aluSrcA_UC    = 2'b10;
    aluSrcB_UC    = 2'b00;
    resSrc_UC     = 2'b00;
    aluControl_UC = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_req      = 1'b1;
        aluSrcA_UC = 2'b00;
        aluSrcB_UC = 2'b10;
        resSrc_UC  = 2'b10;
        w_irw      = memAck_UC;
        w_pcw      = memAck_UC;
      end
      S_DECODE: begin
        aluSrcA_UC = 2'b01;
        aluSrcB_UC = 2'b01;
      end
      S_MEMADR: aluSrcB_UC = 2'b01;
      S_MEMRD: begin
        w_req     = 1'b1;
        adrSrc_UC = 1'b1;
      end
      S_MEMWB: begin
        resSrc_UC = 2'b01;
        w_rw      = 1'b1;
      end
      S_MEMWR: begin
        w_req     = 1'b1;
        w_mwr     = 1'b1;
        adrSrc_UC = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        aluSrcB_UC = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        case (w_f3)
          3'b000:  aluControl_UC = (r_state == S_EXECR && instr_UC[30]) ? 3'b001 : 3'b000;
          3'b010:  aluControl_UC = 3'b101;
          3'b100:  aluControl_UC = 3'b100;
          3'b110:  aluControl_UC = 3'b011;
          3'b111:  aluControl_UC = 3'b010;
          default: aluControl_UC = 3'b000;
        endcase
      end
      S_ALUWB: w_rw = 1'b1;
      S_JAL: begin
        aluSrcA_UC = 2'b01;
        aluSrcB_UC = 2'b10;
        w_pcw      = 1'b1;
      end
      S_BEQ: begin
        aluControl_UC = 3'b001;
        branch_UC     = 1'b1;
        case (w_f3)
          3'b000:  w_pcw = zero_UC;
          3'b001:  w_pcw = ~zero_UC;
          default: w_pcw = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    case (w_op)
      c_op_store: inmSrc_UC = 2'b01;
      c_op_beq:   inmSrc_UC = 2'b10;
      c_op_jal:   inmSrc_UC = 2'b11;
      default:    inmSrc_UC = 2'b00;
    endcase
  end

  // Strobes are suppressed for the whole reset cycle, whatever the state.
  assign memReq_UC   = w_req & ~rst_UC;
  assign memWrite_UC = w_mwr & ~rst_UC;
  assign irWrite_UC  = w_irw & ~rst_UC;
  assign pcWrite_UC  = w_pcw & ~rst_UC;
  assign regWrite_UC = w_rw  & ~rst_UC;
  assign type_UC     = w_f3;
  assign state_UC    = r_state;
  assign fault_UC    = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uc_multiciclo
// Brief   : Directed instruction-level checks of uc_multiciclo control outputs.
// Rev     : 1.0
// ============================================================================
module tb_uc_multiciclo;
  localparam int c_to = 4;

  logic        clk_UC = 1'b0;
  logic        rst_UC = 1'b1;
  logic [31:0] instr_UC = 32'h002081B3;
  logic        zero_UC = 1'b0;
  logic        memAck_UC = 1'b1;
  logic        memReq_UC, memWrite_UC, adrSrc_UC, irWrite_UC, pcWrite_UC;
  logic        regWrite_UC, branch_UC, fault_UC;
  logic [1:0]  aluSrcA_UC, aluSrcB_UC, resSrc_UC, inmSrc_UC;
  logic [2:0]  aluControl_UC, type_UC;
  logic [3:0]  state_UC;

  uc_multiciclo #(.MEM_TIMEOUT(c_to), .CNT_W(5)) dut (
    .clk_UC(clk_UC), .rst_UC(rst_UC), .instr_UC(instr_UC), .zero_UC(zero_UC),
    .memAck_UC(memAck_UC), .memReq_UC(memReq_UC), .memWrite_UC(memWrite_UC),
    .adrSrc_UC(adrSrc_UC), .irWrite_UC(irWrite_UC), .pcWrite_UC(pcWrite_UC),
    .regWrite_UC(regWrite_UC), .branch_UC(branch_UC), .aluSrcA_UC(aluSrcA_UC),
    .aluSrcB_UC(aluSrcB_UC), .resSrc_UC(resSrc_UC), .inmSrc_UC(inmSrc_UC),
    .aluControl_UC(aluControl_UC), .type_UC(type_UC), .state_UC(state_UC),
    .fault_UC(fault_UC)
  );

  always #5 clk_UC = ~clk_UC;

  typedef enum {K_FETCH, K_DEC, K_MADR, K_MRD, K_MWB, K_MWR, K_EXR, K_EXI,
                K_AWB, K_JAL, K_BEQ, K_FLT} kind_e;

  typedef struct packed {
    logic req, mwr, adr, irw, pcw, rw, br;
    logic [1:0] sa, sb, res, inm;
    logic [2:0] alu, typ;
    logic flt;
  } exp_t;

  exp_t  q_exp[$];
  string q_lbl[$];
  int    n_err = 0, n_chk = 0, n_steps = 0;
  int    cnt_req = 0, cnt_pcw = 0, cnt_mwr = 0;

  function automatic logic [2:0] alu_of(logic [31:0] ins, logic is_r);
    case (ins[14:12])
      3'b000:  return (is_r && ins[30]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle, straight from the per-step control table.
  function automatic exp_t ctrl(kind_e k, logic ack, logic [31:0] ins, logic z, logic rst);
    exp_t e = '0;
    e.sa  = 2'b10;
    e.typ = ins[14:12];
    e.inm = (ins[6:0] == 7'b0100011) ? 2'b01 : (ins[6:0] == 7'b1100011) ? 2'b10 :
            (ins[6:0] == 7'b1101111) ? 2'b11 : 2'b00;
    case (k)
      K_FETCH: begin e.req = 1; e.sa = 2'b00; e.sb = 2'b10; e.res = 2'b10; e.irw = ack; e.pcw = ack; end
      K_DEC:   begin e.sa = 2'b01; e.sb = 2'b01; end
      K_MADR:  e.sb = 2'b01;
      K_MRD:   begin e.req = 1; e.adr = 1; end
      K_MWB:   begin e.res = 2'b01; e.rw = 1; end
      K_MWR:   begin e.req = 1; e.mwr = 1; e.adr = 1; end
      K_EXR:   e.alu = alu_of(ins, 1'b1);
      K_EXI:   begin e.sb = 2'b01; e.alu = alu_of(ins, 1'b0); end
      K_AWB:   e.rw = 1;
      K_JAL:   begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
      K_BEQ:   begin
        e.alu = 3'b001; e.br = 1;
        e.pcw = (ins[14:12] == 3'b000) ? z : (ins[14:12] == 3'b001) ? ~z : 1'b0;
      end
      K_FLT:   e.flt = 1;
      default: ;
    endcase
    if (rst) begin e.req = 0; e.mwr = 0; e.irw = 0; e.pcw = 0; e.rw = 0; end
    return e;
  endfunction

  always @(negedge clk_UC) begin
    exp_t act, e;
    string lbl;
    if (memReq_UC) cnt_req++;
    if (pcWrite_UC) cnt_pcw++;
    if (memWrite_UC) cnt_mwr++;
    if (q_exp.size() > 0) begin
      e   = q_exp.pop_front();
      lbl = q_lbl.pop_front();
      act = {memReq_UC, memWrite_UC, adrSrc_UC, irWrite_UC, pcWrite_UC, regWrite_UC,
             branch_UC, aluSrcA_UC, aluSrcB_UC, resSrc_UC, inmSrc_UC, aluControl_UC,
             type_UC, fault_UC};
      n_chk++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s @%0t: got %b want %b", lbl, $time, act, e);
      end
    end
  end

  task automatic step(kind_e k, logic ack);
    memAck_UC = ack;
    q_exp.push_back(ctrl(k, ack, instr_UC, zero_UC, rst_UC));
    q_lbl.push_back(k.name());
    n_steps++;
    @(posedge clk_UC);
    #1;
  endtask

  task automatic chk_lit(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic mem_wait(kind_e k, int dly, output bit ok);
    ok = 0;
    for (int i = 0; i < c_to; i++) begin
      step(k, (i == dly));
      if (i == dly) begin ok = 1; return; end
    end
  endtask

  task automatic fault_tail();
    for (int i = 0; i < 3; i++) step(K_FLT, 1'b1);
  endtask

  task automatic do_reset(int n, kind_e first);
    rst_UC = 1'b1;
    step(first, 1'b1);
    for (int i = 1; i < n; i++) step(K_FETCH, 1'b1);
    rst_UC = 1'b0;
  endtask

  task automatic run_instr(logic [31:0] ins, logic z, int fdly, int mdly);
    bit ok;
    instr_UC = ins;
    zero_UC  = z;
    n_steps  = 0;
    mem_wait(K_FETCH, fdly, ok);
    if (!ok) begin fault_tail(); return; end
    step(K_DEC, 1'b1);
    case (ins[6:0])
      7'b0000011: begin
        step(K_MADR, 1'b1);
        mem_wait(K_MRD, mdly, ok);
        if (!ok) begin fault_tail(); return; end
        step(K_MWB, 1'b1);
      end
      7'b0100011: begin
        step(K_MADR, 1'b1);
        mem_wait(K_MWR, mdly, ok);
        if (!ok) fault_tail();
      end
      7'b0110011: begin step(K_EXR, 1'b1); step(K_AWB, 1'b1); end
      7'b0010011: begin step(K_EXI, 1'b1); step(K_AWB, 1'b1); end
      7'b1101111: begin step(K_JAL, 1'b1); step(K_AWB, 1'b1); end
      7'b1100011: step(K_BEQ, 1'b1);
      default:    fault_tail();
    endcase
  endtask

  initial begin
    int r0, p0, w0;
    @(posedge clk_UC);
    #1;
    do_reset(2, K_FETCH);

    run_instr(32'h002081B3, 1'b0, 0, 0);            // add
    chk_lit("add_latency", n_steps, 4);
    run_instr(32'h002081B3, 1'b0, 2, 0);            // add, two fetch waits
    chk_lit("add_fetch_wait_latency", n_steps, 6);

    r0 = cnt_req;
    run_instr(32'h0040A283, 1'b0, 0, 3);            // lw, ack on last allowed cycle
    chk_lit("lw_wait_latency", n_steps, 8);
    chk_lit("lw_req_cycles", cnt_req - r0, 5);
    run_instr(32'h0040A283, 1'b0, 0, 0);
    chk_lit("lw_latency", n_steps, 5);
    run_instr(32'h0020A423, 1'b0, 0, 1);            // sw
    chk_lit("sw_wait_latency", n_steps, 5);

    run_instr(32'h402081B3, 1'b0, 0, 0);            // sub
    run_instr(32'h0020A1B3, 1'b0, 0, 0);            // slt
    run_instr(32'h0020F1B3, 1'b0, 0, 0);            // and
    run_instr(32'h0020E1B3, 1'b0, 0, 0);            // or
    run_instr(32'h002091B3, 1'b0, 0, 0);            // sll -> add
    run_instr(32'h40000093, 1'b0, 0, 0);            // addi, imm bit 30 set
    run_instr(32'h0040C093, 1'b0, 0, 0);            // xori
    chk_lit("i_latency", n_steps, 4);
    run_instr(32'h008000EF, 1'b0, 0, 0);            // jal
    chk_lit("jal_latency", n_steps, 4);

    p0 = cnt_pcw; run_instr(32'h00208463, 1'b1, 0, 0);
    chk_lit("beq_taken_pcw", cnt_pcw - p0, 2);
    chk_lit("beq_latency", n_steps, 3);
    p0 = cnt_pcw; run_instr(32'h00208463, 1'b0, 0, 0);
    chk_lit("beq_not_taken_pcw", cnt_pcw - p0, 1);
    p0 = cnt_pcw; run_instr(32'h00209463, 1'b1, 0, 0);
    chk_lit("bne_z1_pcw", cnt_pcw - p0, 1);
    p0 = cnt_pcw; run_instr(32'h00209463, 1'b0, 0, 0);
    chk_lit("bne_z0_pcw", cnt_pcw - p0, 2);

    run_instr(32'h0000007F, 1'b0, 0, 0);            // illegal opcode
    chk_lit("illegal_fault", int'(fault_UC), 1);
    do_reset(2, K_FLT);
    chk_lit("fault_cleared", int'(fault_UC), 0);

    r0 = cnt_req;
    run_instr(32'h002081B3, 1'b0, 99, 0);           // fetch timeout
    chk_lit("timeout_req_cycles", cnt_req - r0, 4);
    do_reset(1, K_FLT);
    run_instr(32'h002081B3, 1'b0, 0, 0);

    instr_UC = 32'h0020A423;                        // sw aborted by reset in wait
    step(K_FETCH, 1'b1); step(K_DEC, 1'b0); step(K_MADR, 1'b0);
    step(K_MWR, 1'b0); step(K_MWR, 1'b0);
    w0 = cnt_mwr;
    do_reset(1, K_MWR);
    instr_UC = 32'h002081B3;
    step(K_FETCH, 1'b0);
    chk_lit("no_memwrite_after_reset", cnt_mwr - w0, 0);
    run_instr(32'h002081B3, 1'b0, 0, 0);

    chk_lit("queue_drained", q_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
